// File: rtl/rr_arbiter_16_pkg.sv
// Shared types, sizes and the rotating priority pick for the 16-way round-robin arbiter.
package arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    localparam int N_REQ = 16;
    localparam int IDX_W = 4;

    // Rotate req right by ptr, take the lowest set bit, then map back by adding ptr.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [N_REQ-1:0] req,
        input logic [IDX_W-1:0] ptr
    );
        logic [2*N_REQ-1:0] doubled;
        logic [N_REQ-1:0]   rotated;
        logic [IDX_W-1:0]   offset;
        doubled = {req, req};
        rotated = doubled[ptr +: N_REQ];
        offset  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = IDX_W'(i);
            end
        end
        return ptr + offset;
    endfunction

endpackage

// File: rtl/decoder_4_to_16.sv
// Enabled 4-to-16 one-hot decoder; output is all zero while ena is low.
module decoder_4_to_16 (
    input  logic        ena,
    input  logic [3:0]  in,
    output logic [15:0] out
);

    always_comb begin
        out = '0;
        if (ena) begin
            out[in] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter for 16 requesters with an optional per-grant hold limit.
module rr_arbiter_16
    import arb_pkg::*;
#(
    parameter int HOLD_LIMIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             timeout
);

    localparam logic [7:0] LIMIT_LAST = 8'(HOLD_LIMIT - 1);

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic [7:0]       hold_cnt, hold_nxt;
    logic             timeout_nxt;
    logic             owner_req;
    logic             limit_hit;
    logic             release_now;

    always_comb begin
        owner_req   = req[gnt_idx];
        limit_hit   = (HOLD_LIMIT != 0) && (hold_cnt == LIMIT_LAST);
        release_now = done || !owner_req || limit_hit;

        state_nxt   = state;
        ptr_nxt     = ptr;
        idx_nxt     = gnt_idx;
        hold_nxt    = hold_cnt;
        timeout_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (req != '0) begin
                    state_nxt = GRANT;
                    idx_nxt   = rr_pick(req, ptr);
                    hold_nxt  = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_nxt   = IDLE;
                    ptr_nxt     = gnt_idx + IDX_W'(1);
                    hold_nxt    = '0;
                    // Only a pure limit expiry is flagged; a coincident done or drop is a normal release.
                    timeout_nxt = !done && owner_req;
                end else begin
                    hold_nxt = hold_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            gnt_idx  <= '0;
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            gnt_idx  <= idx_nxt;
            hold_cnt <= hold_nxt;
            timeout  <= timeout_nxt;
        end
    end

    // Grant outputs come only from registers, so req/done never reach gnt combinationally.
    assign gnt_valid = (state == GRANT);

    decoder_4_to_16 u_decoder (
        .ena (gnt_valid),
        .in  (gnt_idx),
        .out (gnt)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert ($onehot0(gnt) && (gnt_valid == |gnt));
        end
    end

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Scoreboard bench: two arbiters (limit 4 and limit 0) share stimulus and are checked against a behavioural model.
module tb_rr_arbiter_16;

    typedef struct {
        logic [15:0] gnt;
        logic        valid;
        logic [3:0]  idx;
        logic        tmo;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic        done;

    logic [15:0] gnt_a, gnt_b;
    logic        valid_a, valid_b;
    logic [3:0]  idx_a, idx_b;
    logic        tmo_a, tmo_b;

    int tests;
    int errors;

    exp_t q_a[$];
    exp_t q_b[$];

    bit m_busy[2];
    int m_idx[2];
    int m_ptr[2];
    int m_hold[2];
    int lim[2];

    rr_arbiter_16 #(.HOLD_LIMIT(4)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt_a),
        .gnt_valid (valid_a),
        .gnt_idx   (idx_a),
        .timeout   (tmo_a)
    );

    rr_arbiter_16 #(.HOLD_LIMIT(0)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt_b),
        .gnt_valid (valid_b),
        .gnt_idx   (idx_b),
        .timeout   (tmo_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] g, input logic v,
                               input logic [3:0] i, input logic t, input exp_t e);
        tests++;
        if (g !== e.gnt || v !== e.valid || i !== e.idx || t !== e.tmo) begin
            errors++;
            $display("[TB] FAIL %s @%0t: got gnt=%h valid=%b idx=%0d timeout=%b, want gnt=%h valid=%b idx=%0d timeout=%b",
                     name, $time, g, v, i, t, e.gnt, e.valid, e.idx, e.tmo);
        end
    endtask

    // Reference: owner tracked as an integer, first requester found by walking ptr..ptr+15 mod 16.
    task automatic modelStep(input int k, input logic [15:0] r, input logic d, output exp_t e);
        bit found;
        int c;
        bit by_limit;
        e.tmo = 1'b0;
        if (!m_busy[k]) begin
            found = 1'b0;
            for (int j = 0; j < 16; j++) begin
                c = (m_ptr[k] + j) % 16;
                if (!found && r[c]) begin
                    found     = 1'b1;
                    m_busy[k] = 1'b1;
                    m_idx[k]  = c;
                    m_hold[k] = 0;
                end
            end
        end else begin
            by_limit = (lim[k] != 0) && (m_hold[k] + 1 == lim[k]);
            if (d || !r[m_idx[k]] || by_limit) begin
                e.tmo     = !d && r[m_idx[k]];
                m_busy[k] = 1'b0;
                m_ptr[k]  = (m_idx[k] + 1) % 16;
                m_hold[k] = 0;
            end else begin
                m_hold[k]++;
            end
        end
        e.gnt   = m_busy[k] ? (16'd1 << m_idx[k]) : 16'd0;
        e.valid = m_busy[k];
        e.idx   = 4'(m_idx[k]);
    endtask

    task automatic resetModel();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 1'b0;
            m_idx[k]  = 0;
            m_ptr[k]  = 0;
            m_hold[k] = 0;
        end
        q_a.delete();
        q_b.delete();
    endtask

    task automatic applyStimulus(input logic [15:0] r, input logic d);
        exp_t e;
        req  = r;
        done = d;
        modelStep(0, r, d, e);
        q_a.push_back(e);
        modelStep(1, r, d, e);
        q_b.push_back(e);
    endtask

    task automatic cycle(input logic [15:0] r, input logic d);
        @(negedge clk);
        applyStimulus(r, d);
    endtask

    task automatic doReset(input logic [15:0] r, input logic d);
        exp_t z;
        z = '{gnt: 16'h0, valid: 1'b0, idx: 4'd0, tmo: 1'b0};
        @(negedge clk);
        req   = r;
        done  = d;
        rst_n = 1'b0;
        resetModel();
        @(negedge clk);
        checkOutput("reset_a", gnt_a, valid_a, idx_a, tmo_a, z);
        checkOutput("reset_b", gnt_b, valid_b, idx_b, tmo_b, z);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(r, d);
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n && q_a.size() > 0) begin
            checkOutput("scoreboard_a", gnt_a, valid_a, idx_a, tmo_a, q_a.pop_front());
        end
        if (rst_n && q_b.size() > 0) begin
            checkOutput("scoreboard_b", gnt_b, valid_b, idx_b, tmo_b, q_b.pop_front());
        end
    end

    initial begin
        exp_t z;
        logic [15:0] r;
        tests  = 0;
        errors = 0;
        lim[0] = 4;
        lim[1] = 0;
        z      = '{gnt: 16'h0, valid: 1'b0, idx: 4'd0, tmo: 1'b0};
        rst_n  = 1'b0;
        req    = 16'hFFFF;
        done   = 1'b0;
        resetModel();

        doReset(16'hFFFF, 1'b0);
        cycle(16'h0000, 1'b0);
        cycle(16'h0000, 1'b0);

        // Single requester with done on the third grant cycle.
        repeat (2) begin
            cycle(16'h0020, 1'b0);
            cycle(16'h0020, 1'b0);
            cycle(16'h0020, 1'b0);
            cycle(16'h0020, 1'b1);
        end
        cycle(16'h0000, 1'b0);

        doReset(16'hFFFF, 1'b1);
        repeat (40) cycle(16'hFFFF, 1'b1);

        doReset(16'h4000, 1'b0);
        cycle(16'h4000, 1'b0);
        cycle(16'h4008, 1'b1);
        cycle(16'h4008, 1'b0);
        cycle(16'h4008, 1'b1);
        cycle(16'h4008, 1'b0);
        cycle(16'h4008, 1'b1);
        cycle(16'h0000, 1'b0);

        doReset(16'h0003, 1'b0);
        repeat (20) cycle(16'h0003, 1'b0);
        cycle(16'h0003, 1'b1);
        cycle(16'h0000, 1'b0);

        doReset(16'h0080, 1'b0);
        cycle(16'h0080, 1'b0);
        cycle(16'h0000, 1'b0);
        cycle(16'h0180, 1'b0);
        cycle(16'h0180, 1'b0);
        cycle(16'h0000, 1'b0);
        cycle(16'h0000, 1'b0);

        // Asynchronous reset while agent 1 holds the grant, then restart from ptr 0.
        doReset(16'hFFFF, 1'b0);
        cycle(16'hFFFF, 1'b1);
        cycle(16'hFFFF, 1'b0);
        cycle(16'hFFFF, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_a", gnt_a, valid_a, idx_a, tmo_a, z);
        checkOutput("async_reset_b", gnt_b, valid_b, idx_b, tmo_b, z);
        resetModel();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(16'hFFFF, 1'b0);
        cycle(16'hFFFF, 1'b1);
        cycle(16'hFFFF, 1'b0);

        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0:       r = 16'($urandom);
                1:       r = 16'd1 << $urandom_range(0, 15);
                2:       r = 16'($urandom) & 16'($urandom) & 16'($urandom);
                default: r = 16'h0;
            endcase
            if ($urandom_range(0, 2) != 0) begin
                r = r | req;
            end
            cycle(r, $urandom_range(0, 5) == 0);
        end

        repeat (3) cycle(16'h0000, 1'b0);
        @(posedge clk);
        #2;
        tests++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d/%0d pending, want 0/0", q_a.size(), q_b.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
